// File: rtl/matrix_pkg.sv
// Shared dimensions, opcodes and FSM state encoding for the matrix operation sequencer.
package matrix_pkg;

  localparam int unsigned DIM    = 5;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned ROW_W  = DIM * ELEM_W;
  localparam int unsigned MAT_W  = DIM * ROW_W;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_TRN = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_DRAIN,
    ST_EXEC,
    ST_WAIT_ULA,
    ST_STORE,
    ST_DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_NEG;
  endfunction

  function automatic logic op_binary(input logic [2:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_row_reg.sv
// matrix_row_reg: full-matrix register with a row-indexed write port, a whole-matrix load and a clear.
module matrix_row_reg #(
  parameter int unsigned ROWS  = matrix_pkg::DIM,
  parameter int unsigned RW    = matrix_pkg::ROW_W,
  parameter int unsigned IDX_W = $clog2(matrix_pkg::DIM + 1)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_row,
  input  logic [RW-1:0]        wr_data,
  input  logic                 ld_en,
  input  logic [ROWS*RW-1:0]   ld_data,
  output logic [ROWS*RW-1:0]   q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld_en) begin
      q <= ld_data;
    end else if (wr_en) begin
      q[RW*wr_row +: RW] <= wr_data;
    end
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Sequences matrix row loads, a ULA operation and result row stores; MATRIX_SEQ_TIMEOUT_EN adds a WAIT_ULA watchdog.
module matrix_op_sequencer #(
  parameter int unsigned DIM    = matrix_pkg::DIM,
  parameter int unsigned ELEM_W = matrix_pkg::ELEM_W,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [2:0]                  opcode,
  input  logic [ADDR_W-1:0]           base_a,
  input  logic [ADDR_W-1:0]           base_b,
  input  logic [ADDR_W-1:0]           base_c,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DIM*ELEM_W-1:0]       mem_rd_data,
  output logic [DIM*ELEM_W-1:0]       mem_wr_data,
  output logic [2:0]                  ula_op,
  output logic                        ula_start,
  output logic [DIM*DIM*ELEM_W-1:0]   ula_a,
  output logic [DIM*DIM*ELEM_W-1:0]   ula_b,
  input  logic [DIM*DIM*ELEM_W-1:0]   ula_result,
  input  logic                        ula_done
);

  localparam int unsigned RW    = DIM * ELEM_W;
  localparam int unsigned MW    = DIM * RW;
  localparam int unsigned CNT_W = $clog2(DIM + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DIM - 1);

  matrix_pkg::state_t state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        op_q, op_n;
  logic [ADDR_W-1:0] ba_q, bb_q, bc_q, ba_n, bb_n, bc_n;
  logic              busy_n, done_n, err_n, rd_n, wr_n, ustart_n;
  logic [ADDR_W-1:0] addr_n;
  logic [RW-1:0]     wdata_n;
  logic [MW-1:0]     res_q, res_src;

  // Read data returns one cycle after the read strobe; these track where it lands.
  logic              rd_pend;
  logic [CNT_W-1:0]  rd_row;
  logic              rd_sel_b;

`ifdef MATRIX_SEQ_TIMEOUT_EN
  logic [7:0] wdog, wdog_n;
`endif

  assign ula_op = op_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= matrix_pkg::ST_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      ba_q        <= '0;
      bb_q        <= '0;
      bc_q        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      ula_start   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rd_pend     <= 1'b0;
      rd_row      <= '0;
      rd_sel_b    <= 1'b0;
`ifdef MATRIX_SEQ_TIMEOUT_EN
      wdog        <= '0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      op_q        <= op_n;
      ba_q        <= ba_n;
      bb_q        <= bb_n;
      bc_q        <= bc_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= err_n;
      mem_rd_en   <= rd_n;
      mem_wr_en   <= wr_n;
      ula_start   <= ustart_n;
      mem_addr    <= addr_n;
      mem_wr_data <= wdata_n;
      rd_pend     <= mem_rd_en;
      rd_row      <= cnt;
      rd_sel_b    <= (state == matrix_pkg::ST_LOAD_B);
`ifdef MATRIX_SEQ_TIMEOUT_EN
      wdog        <= wdog_n;
`endif
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    ba_n    = ba_q;
    bb_n    = bb_q;
    bc_n    = bc_q;
    err_n   = 1'b0;
`ifdef MATRIX_SEQ_TIMEOUT_EN
    wdog_n  = wdog;
`endif
    res_src = (state == matrix_pkg::ST_WAIT_ULA) ? ula_result : res_q;

    case (state)
      matrix_pkg::ST_IDLE: begin
        if (start) begin
          if (matrix_pkg::op_legal(opcode)) begin
            op_n    = opcode;
            ba_n    = base_a;
            bb_n    = base_b;
            bc_n    = base_c;
            cnt_n   = '0;
            state_n = matrix_pkg::ST_LOAD_A;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      matrix_pkg::ST_LOAD_A: begin
        if (cnt == LAST_ROW) begin
          cnt_n   = '0;
          state_n = matrix_pkg::op_binary(op_q) ? matrix_pkg::ST_LOAD_B : matrix_pkg::ST_DRAIN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      matrix_pkg::ST_LOAD_B: begin
        if (cnt == LAST_ROW) begin
          cnt_n   = '0;
          state_n = matrix_pkg::ST_DRAIN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      matrix_pkg::ST_DRAIN: state_n = matrix_pkg::ST_EXEC;
      matrix_pkg::ST_EXEC: begin
        state_n = matrix_pkg::ST_WAIT_ULA;
`ifdef MATRIX_SEQ_TIMEOUT_EN
        wdog_n  = '0;
`endif
      end
      matrix_pkg::ST_WAIT_ULA: begin
        if (ula_done) begin
          cnt_n   = '0;
          state_n = matrix_pkg::ST_STORE;
`ifdef MATRIX_SEQ_TIMEOUT_EN
        end else if (wdog == 8'd254) begin
          err_n   = 1'b1;
          state_n = matrix_pkg::ST_IDLE;
        end else begin
          wdog_n = wdog + 8'd1;
`endif
        end
      end
      matrix_pkg::ST_STORE: begin
        if (cnt == LAST_ROW) begin
          cnt_n   = '0;
          state_n = matrix_pkg::ST_DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      matrix_pkg::ST_DONE: state_n = matrix_pkg::ST_IDLE;
      default:             state_n = matrix_pkg::ST_IDLE;
    endcase

    busy_n   = (state_n != matrix_pkg::ST_IDLE);
    done_n   = (state_n == matrix_pkg::ST_DONE);
    rd_n     = (state_n == matrix_pkg::ST_LOAD_A) || (state_n == matrix_pkg::ST_LOAD_B);
    wr_n     = (state_n == matrix_pkg::ST_STORE);
    ustart_n = (state_n == matrix_pkg::ST_EXEC);
    addr_n   = '0;
    wdata_n  = '0;
    if (state_n == matrix_pkg::ST_LOAD_A) begin
      addr_n = ba_n + ADDR_W'(cnt_n);
    end else if (state_n == matrix_pkg::ST_LOAD_B) begin
      addr_n = bb_n + ADDR_W'(cnt_n);
    end else if (state_n == matrix_pkg::ST_STORE) begin
      addr_n  = bc_n + ADDR_W'(cnt_n);
      wdata_n = res_src[RW*cnt_n +: RW];
    end
  end

  matrix_row_reg #(.ROWS(DIM), .RW(RW), .IDX_W(CNT_W)) u_reg_a (
    .clk     (clk),
    .clr     (!reset_n),
    .wr_en   (rd_pend && !rd_sel_b),
    .wr_row  (rd_row),
    .wr_data (mem_rd_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .q       (ula_a)
  );

  matrix_row_reg #(.ROWS(DIM), .RW(RW), .IDX_W(CNT_W)) u_reg_b (
    .clk     (clk),
    .clr     (!reset_n),
    .wr_en   (rd_pend && rd_sel_b),
    .wr_row  (rd_row),
    .wr_data (mem_rd_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .q       (ula_b)
  );

  matrix_row_reg #(.ROWS(DIM), .RW(RW), .IDX_W(CNT_W)) u_reg_res (
    .clk     (clk),
    .clr     (!reset_n),
    .wr_en   (1'b0),
    .wr_row  ('0),
    .wr_data ('0),
    .ld_en   ((state == matrix_pkg::ST_WAIT_ULA) && ula_done),
    .ld_data (ula_result),
    .q       (res_q)
  );

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Scoreboard bench for matrix_op_sequencer: memory and ULA models, expected reads/writes/events queued at issue.
module tb_matrix_op_sequencer;

  localparam int unsigned DIM = 5;
  localparam int unsigned EW  = 8;
  localparam int unsigned RW  = DIM * EW;
  localparam int unsigned MW  = DIM * RW;
  localparam int unsigned AW  = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [2:0]    opcode;
  logic [AW-1:0] base_a, base_b, base_c;
  logic          busy, done, error;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_rd_data;
  logic [RW-1:0] mem_wr_data;
  logic [2:0]    ula_op;
  logic          ula_start;
  logic [MW-1:0] ula_a, ula_b, ula_result;
  logic          ula_done = 1'b0;

  always #5 clk = ~clk;

  matrix_op_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done), .error(error),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
    .ula_op(ula_op), .ula_start(ula_start), .ula_a(ula_a), .ula_b(ula_b),
    .ula_result(ula_result), .ula_done(ula_done)
  );

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int t0 = 0;
  int ula_delay = 0;
  int ula_wait = 0;
  bit ula_busy = 1'b0;
  bit mon_on = 1'b0;

  typedef struct { int addr; logic [RW-1:0] data; } wr_t;
  typedef struct { bit is_err; int at; } evt_t;
  int   exp_rd[$];
  wr_t  exp_wr[$];
  evt_t exp_evt[$];

  logic [RW-1:0] mem [512];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : '0;

  function automatic logic [MW-1:0] ula_fn(input logic [2:0] op, input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] r;
    logic [EW-1:0] acc;
    r = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        case (op)
          3'd0: r[RW*i+EW*j +: EW] = a[RW*i+EW*j +: EW] + b[RW*i+EW*j +: EW];
          3'd1: r[RW*i+EW*j +: EW] = a[RW*i+EW*j +: EW] - b[RW*i+EW*j +: EW];
          3'd2: begin
            acc = '0;
            for (int k = 0; k < DIM; k++) acc = acc + a[RW*i+EW*k +: EW] * b[RW*k+EW*j +: EW];
            r[RW*i+EW*j +: EW] = acc;
          end
          3'd3: r[RW*i+EW*j +: EW] = a[RW*j+EW*i +: EW];
          default: r[RW*i+EW*j +: EW] = 8'd0 - a[RW*i+EW*j +: EW];
        endcase
      end
    end
    return r;
  endfunction

  // ULA model: ula_done rises ula_delay cycles after the first WAIT_ULA cycle.
  always @(posedge clk) begin
    if (!reset_n) begin
      ula_busy <= 1'b0;
      ula_done <= 1'b0;
    end else if (ula_start) begin
      ula_result <= ula_fn(ula_op, ula_a, ula_b);
      ula_wait   <= 0;
      ula_busy   <= 1'b1;
      ula_done   <= (ula_delay == 0);
    end else if (ula_done) begin
      ula_done <= 1'b0;
      ula_busy <= 1'b0;
    end else if (ula_busy) begin
      ula_wait <= ula_wait + 1;
      if (ula_wait + 1 >= ula_delay) ula_done <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a memory access or a done/error pulse.
  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", MW'(mem_addr), MW'(1'b1) << 300);
        else chk("rd_addr", MW'(mem_addr), MW'(exp_rd.pop_front()));
      end
      if (mem_wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", MW'(mem_addr), MW'(1'b1) << 300);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", MW'(mem_addr), MW'(w.addr));
          chk("wr_data", MW'(mem_wr_data), MW'(w.data));
        end
      end
      if (done || error) begin
        if (exp_evt.size() == 0) chk("evt_unexpected", MW'({done, error}), '0);
        else begin
          evt_t e;
          e = exp_evt.pop_front();
          chk("evt_kind", MW'({done, error}), e.is_err ? MW'(2'b01) : MW'(2'b10));
          chk("evt_cycle", MW'(cyc - t0), MW'(e.at - t0));
        end
      end
      chk("invariants", MW'((mem_rd_en && mem_wr_en) || (done && error) ||
                            (!mem_rd_en && !mem_wr_en && mem_addr != '0) ||
                            (!mem_wr_en && mem_wr_data != '0)), '0);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                       input logic [AW-1:0] bc, input logic [MW-1:0] res, input int dly, input bit exp_store);
    @(posedge clk); #1;
    opcode = op; base_a = ba; base_b = bb; base_c = bc; start = 1'b1;
    ula_delay = dly;
    t0 = cyc;
    if (op > 3'd4) begin
      exp_evt.push_back('{1'b1, t0 + 1});
    end else begin
      for (int r = 0; r < DIM; r++) exp_rd.push_back(int'(AW'(ba + AW'(r))));
      if (op <= 3'd2) for (int r = 0; r < DIM; r++) exp_rd.push_back(int'(AW'(bb + AW'(r))));
      if (exp_store) begin
        for (int r = 0; r < DIM; r++) exp_wr.push_back('{int'(AW'(bc + AW'(r))), res[RW*r +: RW]});
        exp_evt.push_back('{1'b0, t0 + ((op <= 3'd2) ? 19 : 14) + dly});
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk); #1;
      if (!busy && exp_evt.size() == 0 && exp_rd.size() == 0 && exp_wr.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: busy=%0b pending rd=%0d wr=%0d evt=%0d", name, busy,
               exp_rd.size(), exp_wr.size(), exp_evt.size());
      exp_rd.delete(); exp_wr.delete(); exp_evt.delete();
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},   MW'(busy), '0);
    chk({tag, "_done"},   MW'(done), '0);
    chk({tag, "_error"},  MW'(error), '0);
    chk({tag, "_rd_en"},  MW'(mem_rd_en), '0);
    chk({tag, "_wr_en"},  MW'(mem_wr_en), '0);
    chk({tag, "_ustart"}, MW'(ula_start), '0);
    chk({tag, "_addr"},   MW'(mem_addr), '0);
    chk({tag, "_wdata"},  MW'(mem_wr_data), '0);
    chk({tag, "_ula_op"}, MW'(ula_op), '0);
  endtask

  logic [MW-1:0] exp_res;
  logic [RW-1:0] row;

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = '0; base_a = '0; base_b = '0; base_c = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int r = 0; r < DIM; r++) begin
      mem[16 + r]  = 40'h0101010101;
      mem[32 + r]  = 40'h0202020202;
      mem[510]     = 40'h0101010101;
      mem[511]     = 40'h0101010101;
      mem[r]       = 40'h0101010101;
      for (int j = 0; j < DIM; j++) row[EW*j +: EW] = EW'(10 * r + j);
      mem[80 + r]  = row;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    reset_n = 1'b1;
    mon_on  = 1'b1;

    // add: 1 + 2 = 3 everywhere
    issue(3'd0, 9'h010, 9'h020, 9'h030, {5{40'h0303030303}}, 0, 1'b1);
    wait_idle(60, "add");

    // sub: 1 - 2 = 0xFF everywhere
    issue(3'd1, 9'h010, 9'h020, 9'h038, {5{40'hFFFFFFFFFF}}, 0, 1'b1);
    wait_idle(60, "sub");

    // mul: each element sums five 1*2 products = 0x0A
    issue(3'd2, 9'h010, 9'h020, 9'h040, {5{40'h0A0A0A0A0A}}, 0, 1'b1);
    wait_idle(60, "mul");

    // transpose of A(i,j)=10*i+j: row r element j = 10*j+r
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) exp_res[RW*r + EW*j +: EW] = EW'(10 * j + r);
    issue(3'd3, 9'h050, 9'h1AA, 9'h060, exp_res, 0, 1'b1);
    wait_idle(60, "transpose");

    // negate: -1 = 0xFF
    issue(3'd4, 9'h010, 9'h000, 9'h068, {5{40'hFFFFFFFFFF}}, 0, 1'b1);
    wait_idle(60, "negate");

    // illegal opcode: error one cycle after start, no access, busy stays low
    issue(3'd6, 9'h010, 9'h020, 9'h070, '0, 0, 1'b0);
    chk("illegal_busy", MW'(busy), '0);
    wait_idle(10, "illegal");

    // base_a wraps 1FE..002; starts while busy are ignored
    issue(3'd0, 9'h1FE, 9'h020, 9'h078, {5{40'h0303030303}}, 0, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; opcode = 3'd1; base_a = 9'h100;
    @(posedge clk); #1;
    opcode = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(60, "wrap");

    // reset during STORE row 2: rows 0..2 written, then nothing
    issue(3'd0, 9'h010, 9'h020, 9'h090, '0, 0, 1'b0);
    for (int r = 0; r < 3; r++) exp_wr.push_back('{int'(9'h090) + r, 40'h0303030303});
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_quiet("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midreset_pending_wr", MW'(exp_wr.size()), '0);
    issue(3'd0, 9'h010, 9'h020, 9'h0A0, {5{40'h0303030303}}, 0, 1'b1);
    wait_idle(60, "after_reset");

`ifdef MATRIX_SEQ_TIMEOUT_EN
    // ULA never answers: error after 255 WAIT_ULA cycles, no store
    issue(3'd0, 9'h010, 9'h020, 9'h0B0, '0, 100000, 1'b0);
    exp_evt.push_back('{1'b1, t0 + 268});
    wait_idle(400, "timeout");
`else
    // ULA answers late, at cycle 300: done six cycles later
    issue(3'd0, 9'h010, 9'h020, 9'h0B0, {5{40'h0303030303}}, 287, 1'b1);
    wait_idle(400, "slow_ula");
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("left_rd",  MW'(exp_rd.size()), '0);
    chk("left_wr",  MW'(exp_wr.size()), '0);
    chk("left_evt", MW'(exp_evt.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_op_sequencer.md
MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

Interface
REQ-001 SHALL have parameter DIM, default 5, matrix dimension (rows = columns).
REQ-002 SHALL have parameter ELEM_W, default 8, element width in bits; row width ROW_W = DIM*ELEM_W (40), matrix width MAT_W = DIM*ROW_W (200).
REQ-003 SHALL have parameter ADDR_W, default 9, memory row-address width.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising edge); reset_n input 1.
REQ-005 SHALL have ports start input 1 (command strobe); opcode input 3; base_a, base_b, base_c input ADDR_W (row base addresses of A, B and result).
REQ-006 SHALL have ports busy output 1; done output 1 (one-cycle pulse); error output 1 (one-cycle pulse).
REQ-007 SHALL have memory ports mem_rd_en output 1; mem_wr_en output 1; mem_addr output ADDR_W; mem_rd_data input ROW_W (valid the cycle after mem_rd_en); mem_wr_data output ROW_W.
REQ-008 SHALL have ULA ports ula_op output 3; ula_start output 1 (pulse); ula_a, ula_b output MAT_W; ula_result input MAT_W; ula_done input 1.

Function
REQ-009 SHALL hold matrices row-major: element (i,j) at bits [ROW_W*i + ELEM_W*j +: ELEM_W]; memory row r of a matrix is at base + r.
REQ-010 SHALL use opcodes 0 add, 1 sub, 2 mul (binary); 3 transpose, 4 negate (unary); 5-7 illegal.
REQ-011 SHALL implement states IDLE, LOAD_A, LOAD_B, DRAIN, EXEC, WAIT_ULA, STORE, DONE.
REQ-012 SHALL, in IDLE with start=1 and a legal opcode, latch opcode and the three bases, then go to LOAD_A; an illegal opcode SHALL pulse error the next cycle and stay in IDLE.
REQ-013 SHALL ignore start whenever busy=1.
REQ-014 SHALL assert busy in every state except IDLE.
REQ-015 SHALL, in LOAD_A, issue reads base_a+0..base_a+DIM-1 over DIM consecutive cycles, with mem_rd_en=1 on each.
REQ-016 SHALL capture mem_rd_data into row r of the A register one cycle after row r's read.
REQ-017 SHALL go from LOAD_A to LOAD_B for binary ops and to DRAIN for unary ops.
REQ-018 SHALL, in LOAD_B, read B in the same way, overlapping the capture of A's last row, then go to DRAIN.
REQ-019 SHALL spend exactly one cycle in DRAIN, which captures the last row.
REQ-020 SHALL, in EXEC, pulse ula_start for one cycle with ula_op = latched opcode, then go to WAIT_ULA.
REQ-021 SHALL drive ula_a and ula_b continuously from the A and B registers; for unary ops the B register is don't-care.
REQ-022 SHALL, in WAIT_ULA, latch ula_result on the first cycle ula_done=1 and go to STORE.
REQ-023 SHALL, in STORE, write rows 0..DIM-1 of the result to base_c+r over DIM cycles, with mem_wr_en=1.
REQ-024 SHALL pulse done for one cycle in DONE, then return to IDLE; done and error SHALL never assert together.
REQ-025 SHALL compute all address arithmetic modulo 2^ADDR_W (wrap-around permitted).
REQ-026 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.
REQ-027 SHALL hold mem_addr and mem_wr_data at 0 when the corresponding enable is low.
REQ-028 SHALL give latency from the start cycle (cycle 0), with ula_done asserted on the first WAIT_ULA cycle: done at cycle 19 for binary ops and cycle 14 for unary ops.

Reset
REQ-029 SHALL, with reset_n=0 at a clock edge, enter IDLE and clear all registers.
REQ-030 SHALL drive busy, done, error, mem_rd_en, mem_wr_en, ula_start, mem_addr, mem_wr_data and ula_op to 0 during reset.
REQ-031 SHALL, on reset mid-operation, abort without further memory writes.

Configuration
REQ-032 SHALL, with MATRIX_SEQ_TIMEOUT_EN defined, run an 8-bit watchdog in WAIT_ULA; if ula_done has not been seen after 255 cycles, it SHALL pulse error, perform no STORE and return to IDLE.
REQ-033 SHALL, without MATRIX_SEQ_TIMEOUT_EN, wait in WAIT_ULA indefinitely.

Structure
REQ-034 SHALL take DIM, ELEM_W, ROW_W, MAT_W, the opcode constants and the state enum from shared package matrix_pkg.
REQ-035 SHALL use one sub-module, matrix_row_reg: a MAT_W register with a row-indexed ROW_W write port and a clear, instantiated for A, B and the result.

Verification
REQ-036 Add, A rows all 8'h01, B rows all 8'h02, ULA model returns A+B -> 5 writes at base_c..base_c+4 of 40'h0303030303; done at cycle 19.
REQ-037 Transpose, A(i,j)=10*i+j, model returns ULA transpose -> row r written as {10*j+r}; LOAD_B skipped; done at cycle 14.
REQ-038 opcode=6 -> error pulse one cycle after start, no memory access, busy stays 0.
REQ-039 base_a=9'h1FE -> reads 1FE, 1FF, 000, 001, 002; start pulsed during LOAD_A -> ignored.
REQ-040 reset_n=0 during STORE row 2 -> no further writes; outputs 0; a new add afterwards completes correctly.
REQ-041 With MATRIX_SEQ_TIMEOUT_EN, ula_done held 0 -> error after 255 WAIT_ULA cycles, no writes; without the macro -> completes once ula_done rises at cycle 300.
